// File: rtl/cp0_unit.sv
// cp0_unit -- Coprocessor 0 for the P7 pipeline (M stage).
//
// Takes the exception-tagged M-stage instruction and six level-sensitive
// hardware interrupt lines. It raises a combinational flush/redirect request
// and holds SR, Cause, EPC, PRId and an optional Count register.
//
// Optional feature macro: CP0_COUNT_EN
//   Defined   : register 9 is a free-running 32-bit Count, loadable by mtc0.
//   Undefined : no Count register; address 9 reads 0 and ignores writes.
//
// Ports:
//   clk      in   1   clock, all state updates on the rising edge
//   reset    in   1   synchronous active-high reset
//   en       in   1   mtc0 write enable
//   addr     in   5   CP0 register number (read and write)
//   wdata    in  32   mtc0 write data
//   pc_m     in  32   PC of the M-stage instruction
//   bd_m     in   1   M-stage instruction sits in a branch delay slot
//   exc_m    in   5   M-stage exception code, 0 = none
//   exl_clr  in   1   eret in M
//   hw_int   in   6   external interrupt lines
//   req      out  1   take exception/interrupt this cycle (combinational)
//   epc_out  out 32   current EPC
//   rdata    out 32   mfc0 read data (pre-edge register values)
//
// Handshake: none. req is a single-cycle combinational strobe; the pipeline
// flushes on the same edge at which this unit records EPC and Cause.
module cp0_unit #(
  parameter logic [31:0] PRID_VAL = 32'h2024_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_m,
  input  logic        exl_clr,
  input  logic [5:0]  hw_int,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] rdata
);

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // EPC
  logic [31:0] epc_q, epc_d;
`ifdef CP0_COUNT_EN
  logic [31:0] count_q, count_d;
`endif

  logic irq;
  logic exc;
  logic wr_ok;

  // EXL masks both interrupt and exception sources: no nesting.
  assign irq   = (|(hw_int & im_q)) & ie_q & ~exl_q;
  assign exc   = (exc_m != 5'd0) & ~exl_q;
  assign req   = irq | exc;
  // A taken exception suppresses any mtc0/eret in the same cycle.
  assign wr_ok = ~req;

  assign epc_out = epc_q;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    // Pending interrupt lines are sampled every cycle unconditionally.
    ip_d       = hw_int;

    if (req) begin
      exl_d      = 1'b1;
      bd_d       = bd_m;
      exc_code_d = irq ? 5'd0 : exc_m;
      epc_d      = bd_m ? (pc_m - 32'd4) : pc_m;
    end else begin
      if (en && addr == 5'd12) begin
        im_d  = wdata[15:10];
        exl_d = wdata[1];
        ie_d  = wdata[0];
      end
      if (en && addr == 5'd14) begin
        epc_d = wdata;
      end
      // eret wins over an EXL bit written in the same cycle.
      if (exl_clr) begin
        exl_d = 1'b0;
      end
    end
  end

`ifdef CP0_COUNT_EN
  always_comb begin
    count_d = count_q + 32'd1;
    if (en && wr_ok && addr == 5'd9) begin
      count_d = wdata;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
`ifdef CP0_COUNT_EN
      count_q    <= '0;
`endif
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
`ifdef CP0_COUNT_EN
      count_q    <= count_d;
`endif
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
`ifdef CP0_COUNT_EN
      5'd9:  rdata = count_q;
`endif
      5'd12: rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
      5'd13: rdata = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
      5'd14: rdata = epc_q;
      5'd15: rdata = PRID_VAL;
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Testbench for cp0_unit: directed steps from the test plan followed by
// randomized traffic, checked against a word-level reference model.
module tb_cp0_unit;
  localparam logic [31:0] PRID = 32'h2024_0007;
  localparam logic [31:0] SR_MASK = 32'h0000_FC03;

  // Clock / reset
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset;
  logic        en;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_m;
  logic        exl_clr;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] rdata;

  cp0_unit #(.PRID_VAL(PRID)) dut (
    .clk(clk), .reset(reset), .en(en), .addr(addr), .wdata(wdata),
    .pc_m(pc_m), .bd_m(bd_m), .exc_m(exc_m), .exl_clr(exl_clr),
    .hw_int(hw_int), .req(req), .epc_out(epc_out), .rdata(rdata)
  );

  // Reference model: architectural register words
  logic [31:0] m_sr, m_cause, m_epc, m_count;
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic m_irq();
    return ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_irq() || ((exc_m != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
`ifdef CP0_COUNT_EN
      5'd9:  return m_count;
`endif
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return PRID;
      default: return 32'd0;
    endcase
  endfunction

  // Model update at an edge, using the inputs held across that edge.
  task automatic model_edge();
    logic        r, i;
    logic [31:0] sr_n, cause_n, epc_n, cnt_n;
    r = m_req();
    i = m_irq();
    sr_n = m_sr; cause_n = m_cause; epc_n = m_epc;
    cnt_n = m_count + 32'd1;
    cause_n = (cause_n & ~32'h0000_FC00) | (32'(hw_int) << 10);
    if (r) begin
      sr_n = sr_n | 32'h2;
      cause_n = (cause_n & ~32'h8000_007C) | (32'(bd_m) << 31)
              | ((i ? 32'd0 : 32'(exc_m)) << 2);
      epc_n = bd_m ? pc_m - 32'd4 : pc_m;
    end else begin
      if (en && addr == 5'd12) sr_n = wdata & SR_MASK;
      if (en && addr == 5'd14) epc_n = wdata;
      if (exl_clr) sr_n = sr_n & ~32'h2;
      if (en && addr == 5'd9) cnt_n = wdata;
    end
    if (reset) begin
      sr_n = 0; cause_n = 0; epc_n = 0; cnt_n = 0;
    end
    m_sr = sr_n; m_cause = cause_n; m_epc = epc_n; m_count = cnt_n;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, then clock one edge.
  task automatic cycle(input string tag);
    #1;
    exp_q.push_back({31'd0, m_req()});
    exp_q.push_back(m_epc);
    exp_q.push_back(m_read(addr));
    cmp({tag, ".req"}, {31'd0, req}, exp_q.pop_front());
    cmp({tag, ".epc"}, epc_out, exp_q.pop_front());
    cmp({tag, ".rdata"}, rdata, exp_q.pop_front());
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Read a register combinationally, check against a fixed value.
  task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    cmp(tag, rdata, exp);
  endtask

  task automatic idle();
    en = 0; wdata = 0; exc_m = 0; exl_clr = 0; bd_m = 0;
  endtask

  logic [4:0] addr_pool [7];

  initial begin
    addr_pool = '{5'd9, 5'd12, 5'd13, 5'd14, 5'd15, 5'd7, 5'd0};
    reset = 1; idle(); addr = 0; pc_m = 0; hw_int = 0;
    repeat (2) @(posedge clk);
    m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0;
    @(negedge clk);

    // Reset state
    cycle("reset");
    peek("reset_sr", 5'd12, 32'd0);
    peek("reset_prid", 5'd15, PRID);
    reset = 0;

    // Count after reset: five edges, then read 5
    addr = 5'd9;
    repeat (5) cycle("count_run");
`ifdef CP0_COUNT_EN
    peek("count5", 5'd9, 32'd5);
`else
    peek("count5", 5'd9, 32'd0);
`endif

    // Interrupt via SR write
    en = 1; addr = 5'd12; wdata = 32'h0000_0401; hw_int = 6'b000001; pc_m = 32'h3000;
    cycle("mtc0_sr");
    idle();
    #1 cmp("irq_req", {31'd0, req}, 32'd1);
    cycle("irq_take");
    peek("irq_cause", 5'd13, 32'h0000_0400);
    peek("irq_sr", 5'd12, 32'h0000_0403);
    cmp("irq_epc", epc_out, 32'h3000);

    // Ov in delay slot
    hw_int = 0; exl_clr = 1;
    cycle("eret1");
    idle(); exc_m = 5'd12; bd_m = 1; pc_m = 32'h3010;
    #1 cmp("ov_req", {31'd0, req}, 32'd1);
    cycle("ov_take");
    idle();
    cmp("ov_epc", epc_out, 32'h300C);
    peek("ov_cause", 5'd13, 32'h8000_0030);

    // EXL masks everything; eret then re-exposes the pending interrupt
    exc_m = 5'd10; hw_int = 6'b000001; pc_m = 32'h3050;
    #1 cmp("exl_mask_req", {31'd0, req}, 32'd0);
    cycle("exl_mask");
    idle();
    cmp("exl_mask_epc", epc_out, 32'h300C);
    peek("exl_mask_cause", 5'd13, 32'h8000_0430);
    exl_clr = 1;
    cycle("eret2");
    idle();
    #1 cmp("eret_irq_req", {31'd0, req}, 32'd1);
    cycle("irq_take2");
    hw_int = 0; exl_clr = 1;
    cycle("eret3");

    // mtc0 EPC suppressed by simultaneous exception
    idle(); en = 1; addr = 5'd14; wdata = 32'h3400; exc_m = 5'd4; pc_m = 32'h3020;
    cycle("epc_suppress");
    idle();
    cmp("epc_suppress_val", epc_out, 32'h3020);

    // PRId, unmapped, Cause write ignored
    peek("prid", 5'd15, PRID);
    peek("unmapped7", 5'd7, 32'd0);
    en = 1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
    cycle("cause_wr");
    idle();
    peek("cause_unch", 5'd13, 32'h0000_0010);

    // Count load and wrap
    en = 1; addr = 5'd9; wdata = 32'hFFFF_FFFF;
    cycle("count_ld");
    idle();
`ifdef CP0_COUNT_EN
    peek("count_ld_val", 5'd9, 32'hFFFF_FFFF);
`else
    peek("count_ld_val", 5'd9, 32'd0);
`endif
    cycle("count_wrap");
    peek("count_wrap_val", 5'd9, 32'd0);

    // mtc0 SR with eret: EXL ends 0 (EXL currently 1, so no req)
    en = 1; addr = 5'd12; wdata = 32'h0000_0403; exl_clr = 1;
    cycle("sr_eret");
    idle();
    peek("sr_eret_val", 5'd12, 32'h0000_0401);

    // Reset mid-exception clears EXL
    exc_m = 5'd1; pc_m = 32'h3100;
    cycle("pre_reset_exc");
    idle(); reset = 1;
    cycle("reset_mid");
    reset = 0;
    peek("reset_mid_sr", 5'd12, 32'd0);
    cmp("reset_mid_epc", epc_out, 32'd0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      reset   = ($urandom_range(0, 49) == 0);
      en      = ($urandom_range(0, 3) == 0);
      addr    = addr_pool[$urandom_range(0, 6)];
      wdata   = $urandom;
      pc_m    = {$urandom} & 32'hFFFF_FFFC;
      bd_m    = 1'($urandom_range(0, 1));
      exc_m   = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      exl_clr = ($urandom_range(0, 7) == 0);
      hw_int  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 for the P7 pipeline. It receives the exception-tagged instruction leaving the E→M pipeline register and the six external hardware interrupt lines. It raises `req`, the flush/redirect that sends the pipeline registers to PC 0x4180, and holds SR, Cause, EPC and an optional Count register for `mfc0`/`mtc0`/`eret`. It sits in the M stage and consumes the M-stage copies of the exception code, BD flag, PC, CP0 write enable, register number and EXL-clear.

## Interface
Parameters:
- `PRID_VAL`, default 32'h2024_0007: value read from CP0 register 15 (PRId).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  `mtc0` write enable (M stage).
- `addr`  in  5  CP0 register number, used for both read and write.
- `wdata`  in  32  `mtc0` write data.
- `pc_m`  in  32  PC of the M-stage instruction.
- `bd_m`  in  1  M-stage instruction is in a branch delay slot.
- `exc_m`  in  5  M-stage exception code; 0 (`Int`) means none.
- `exl_clr`  in  1  `eret` in M.
- `hw_int`  in  6  external interrupt lines, level-sensitive.
- `req`  out  1  take exception/interrupt this cycle (combinational).
- `epc_out`  out  32  current EPC register value (combinational).
- `rdata`  out  32  `mfc0` read data (combinational).

## Operation
Registers:
- SR (12): IM[15:10], EXL[1] and IE[0] are stored; all other bits read 0.
- Cause (13): BD[31], IP[15:10] and ExcCode[6:2] are stored; all other bits read 0.
- EPC (14): full 32 bits.
- PRId (15): constant `PRID_VAL`.
- Count (9): only with the macro (see Configuration).
- Every other `addr` reads 0.

Request logic:
- `irq = |(hw_int & SR.IM) & SR.IE & ~SR.EXL`
- `exc = (exc_m != 0) & ~SR.EXL`
- `req = irq | exc`
- An interrupt has priority over a synchronous exception.

On a clock edge with `req` = 1:
- SR.EXL ← 1.
- Cause.BD ← `bd_m`.
- Cause.ExcCode ← 0 if `irq`, otherwise `exc_m`.
- EPC ← `bd_m` ? `pc_m` − 4 : `pc_m`, modulo 2^32.

Every cycle:
- Cause.IP ← `hw_int`, regardless of `req`.

`mtc0`, on an edge with `en` = 1 and `req` = 0:
- `addr` 12 writes IM, EXL and IE from the same bit positions of `wdata`.
- `addr` 14 writes EPC.
- Cause and PRId ignore writes.
- If `req` = 1, the write is suppressed entirely.

`eret`:
- With `exl_clr` = 1 and `req` = 0, SR.EXL ← 0 at the edge.
- If `req` is also 1, EXL ends at 1.

Simultaneous events:
- An `mtc0` to SR together with `exl_clr` (not a legal pipeline case) leaves EXL at 0. `exl_clr` takes priority over the written EXL bit.

Reads:
- `rdata` always reflects the register value before the edge. There is no write-to-read bypass.

## Timing
- `req` is combinational from the current SR, `hw_int` and `exc_m`. Its latency is 0 cycles, so the pipeline registers flush at the same edge CP0 records EPC.
- State changes become visible 1 cycle after the edge.
- Register reset values: SR = 0, Cause = 0, EPC = 0, Count = 0.
- Output values during reset:
  - `req` = 0, because IE = 0 and EXL = 0 with `exc_m` driven 0 by the reset pipeline.
  - `epc_out` = 0.
  - `rdata` = 0 for any `addr` other than 15.
- Reset has priority over every other update in the same cycle. A reset asserted mid-exception clears EXL.
- While EXL = 1, both `exc_m` and `hw_int` are ignored. No nested exceptions are taken.

## Configuration
`CP0_COUNT_EN`:
- Defined:
  - CP0 register 9 is a 32-bit Count.
  - It increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
  - An `mtc0` to `addr` 9 with `req` = 0 loads `wdata` instead of incrementing, so the next cycle reads `wdata`.
  - Count keeps counting during EXL and when `req` = 1.
- Undefined:
  - No Count register is built.
  - `addr` 9 reads 0 and writes are ignored.

## Test plan
- Reset, then `mtc0` SR = 0x0000_0401 with `hw_int` = 6'b000001 → `req` = 1 on the next cycle. On the following edge Cause.ExcCode = 0, Cause.IP = 0x01, SR.EXL = 1, EPC = `pc_m`.
- `exc_m` = 12 (Ov), `bd_m` = 1, `pc_m` = 0x3010, EXL = 0 → `req` = 1. Then EPC = 0x300C, Cause = 0x8000_0030.
- With EXL = 1, drive `exc_m` = 10 and `hw_int` enabled → `req` = 0 and no state change. Then `exl_clr` = 1 → EXL = 0 next cycle, and `req` rises if the interrupt is still pending.
- `mtc0` EPC = 0x3400 in the same cycle as `exc_m` = 4 at `pc_m` = 0x3020 → write suppressed, EPC = 0x3020.
- With `CP0_COUNT_EN`: after reset, `mfc0` 9 at cycle 5 reads 5. `mtc0` 9 = 0xFFFF_FFFF reads back 0xFFFF_FFFF, then 0 on the next cycle. Without the macro, `mfc0` 9 reads 0.
- `mfc0` 15 → `PRID_VAL`. `mfc0` 7 → 0. `mtc0` Cause = 0xFFFF_FFFF → Cause unchanged.
